slice_packer: RTL and testbench

SLICE_PACKER -- requirements
Module: slice_packer

---
 rtl/slice_packer.sv | 156 +++++++++++++++
 tb/tb_slice_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_packer.sv
// slice_packer
//   Packs RATIO consecutive IN_W-bit input slices into one OUT_W-bit word.
//   Slice k of a word lands at out_data[k*IN_W +: IN_W] (slice 0 is least
//   significant). A slice with in_last=1 closes the word early; the unfilled
//   positions are zero-filled by default.
//
//   Optional build macro:
//     SLICE_PACKER_SIGN_EXT_EN - unfilled positions of a partial word are
//                                filled with copies of bit IN_W-1 of the last
//                                valid slice instead of zeros.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input slice offered
//   in_ready   out  slice accepted when in_valid && in_ready
//   in_data    in   slice payload (IN_W)
//   in_last    in   slice closes the current word
//   out_valid  out  packed word available
//   out_ready  in   word consumed when out_valid && out_ready
//   out_data   out  packed word (IN_W*RATIO)
//   out_count  out  number of valid slices in out_data (1..RATIO)
module slice_packer #(
  parameter int IN_W  = 64,
  parameter int RATIO = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IN_W*RATIO-1:0]       out_data,
  output logic [$clog2(RATIO):0]      out_count
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  // Accumulator. While acc_done_q is set, acc_cnt_q holds the index of the
  // last valid slice of the parked word (so its count is acc_cnt_q + 1).
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             acc_done_q, acc_done_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             accept_s;
  logic             complete_s;
  logic             out_free_s;
  logic [IN_W-1:0]  fill_s;
  logic [OUT_W-1:0] merged_s;

  // in_ready depends on registered state only, never on in_valid/out_ready.
  assign in_ready   = !acc_done_q;
  assign accept_s   = in_valid && !acc_done_q;
  assign complete_s = accept_s && ((acc_cnt_q == LAST_IDX) || in_last);
  assign out_free_s = !out_valid_q || out_ready;

`ifdef SLICE_PACKER_SIGN_EXT_EN
  assign fill_s = {IN_W{in_data[IN_W-1]}};
`else
  assign fill_s = {IN_W{1'b0}};
`endif

  // Merge the incoming slice into the accumulator image. Positions above the
  // new slice get the fill pattern so a word closed here is already final;
  // for an unfinished word those positions are overwritten by later slices.
  always_comb begin
    merged_s = {OUT_W{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) < acc_cnt_q) begin
        merged_s[k*IN_W +: IN_W] = acc_q[k*IN_W +: IN_W];
      end else if (CNT_W'(k) == acc_cnt_q) begin
        merged_s[k*IN_W +: IN_W] = in_data;
      end else begin
        merged_s[k*IN_W +: IN_W] = fill_s;
      end
    end
  end

  // Next-state logic for accumulator and output register.
  always_comb begin
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    acc_done_d  = acc_done_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    // A consumed word drops out_valid unless a new word is loaded below.
    out_valid_d = out_ready ? 1'b0 : out_valid_q;

    if (acc_done_q) begin
      if (out_free_s) begin
        // Parked word moves to the output register.
        out_data_d  = acc_q;
        out_count_d = acc_cnt_q + CNT_ONE;
        out_valid_d = 1'b1;
        acc_cnt_d   = {CNT_W{1'b0}};
        acc_done_d  = 1'b0;
      end else begin
        acc_done_d  = 1'b1;
      end
    end else if (accept_s) begin
      if (complete_s) begin
        if (out_free_s) begin
          // Completing slice goes straight to the output: no bubble.
          out_data_d  = merged_s;
          out_count_d = acc_cnt_q + CNT_ONE;
          out_valid_d = 1'b1;
          acc_cnt_d   = {CNT_W{1'b0}};
        end else begin
          // Output busy: park the finished word and stall the input.
          acc_d      = merged_s;
          acc_done_d = 1'b1;
        end
      end else begin
        acc_d     = merged_s;
        acc_cnt_d = acc_cnt_q + CNT_ONE;
      end
    end else begin
      acc_cnt_d = acc_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= {OUT_W{1'b0}};
      acc_cnt_q   <= {CNT_W{1'b0}};
      acc_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      out_count_q <= {CNT_W{1'b0}};
    end else begin
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_done_q  <= acc_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_slice_packer.sv
// tb_slice_packer
//   Scoreboard bench for slice_packer. The stimulus process drives slices;
//   a monitor process records every accepted slice in a queue-based word
//   model and compares each delivered word with the model's expectation.
module tb_slice_packer;

  localparam int IN_W  = 64;
  localparam int RATIO = 8;
  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO) + 1;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  // small configuration instance: IN_W=4, RATIO=4
  logic        s_in_valid;
  logic        s_in_ready;
  logic [3:0]  s_in_data;
  logic        s_in_last;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic [2:0]  s_out_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_or = 1'b0;

  logic [IN_W-1:0] cur_q[$];
  exp_t            exp_q[$];
  int              out_cyc[$];

  slice_packer #(.IN_W(IN_W), .RATIO(RATIO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  slice_packer #(.IN_W(4), .RATIO(4)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data), .out_count(s_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [IN_W-1:0] fill_of(input logic [IN_W-1:0] last_slice);
`ifdef SLICE_PACKER_SIGN_EXT_EN
    return {IN_W{last_slice[IN_W-1]}};
`else
    return {IN_W{1'b0}};
`endif
  endfunction

  task automatic chk(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Word model: collect accepted slices; a word closes on in_last or RATIO slices.
  initial forever begin
    exp_t e;
    logic [OUT_W-1:0] hold_d;
    logic [CNT_W-1:0] hold_c;
    bit hold_v;
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      cur_q.delete();
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        n_tests++;
        if (out_data !== hold_d || out_count !== hold_c) begin
          n_fail++;
          $display("FAIL hold_stable: got %0d/%0h expected %0d/%0h", out_count, out_data, hold_c, hold_d);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        out_cyc.push_back(cyc);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %0d/%0h expected none", out_count, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_count !== e.cnt) begin
            n_fail++;
            $display("FAIL word: got %0d/%0h expected %0d/%0h", out_count, out_data, e.cnt, e.data);
          end
        end
      end
      hold_v = (out_valid === 1'b1) && (out_ready !== 1'b1);
      hold_d = out_data;
      hold_c = out_count;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        cur_q.push_back(in_data);
        if (in_last === 1'b1 || cur_q.size() == RATIO) begin
          e.cnt = CNT_W'(cur_q.size());
          for (int k = 0; k < RATIO; k++) begin
            if (k < cur_q.size()) e.data[k*IN_W +: IN_W] = cur_q[k];
            else                  e.data[k*IN_W +: IN_W] = fill_of(cur_q[cur_q.size()-1]);
          end
          exp_q.push_back(e);
          cur_q.delete();
        end
      end
    end
  end

  // Offer one slice until accepted (bounded); waits = cycles in_ready was low.
  task automatic send(input logic [IN_W-1:0] d, input logic l, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int tot;
    bit seen;
    logic [3:0] sv[4];
    sv = '{4'h1, 4'h2, 4'h3, 4'hF};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = 4'h0; s_in_last = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", OUT_W'(out_valid), OUT_W'(1'b0));
    chk("rst_in_ready",  OUT_W'(in_ready),  OUT_W'(1'b1));
    chk("rst_out_count", OUT_W'(out_count), OUT_W'(0));
    chk("rst_out_data",  out_data,          {OUT_W{1'b0}});
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // full word 0..7, latency 1
    for (int k = 0; k < RATIO; k++) send(IN_W'(k), 1'b0, w);
    @(negedge clk);
    chk("full_latency_valid", OUT_W'(out_valid), OUT_W'(1'b1));
    @(negedge clk);
    chk("full_single_cycle", OUT_W'(out_valid), OUT_W'(1'b0));
    idle(2);

    // streaming 24 slices, no stall, words 8 cycles apart
    out_cyc.delete();
    tot = 0;
    for (int k = 0; k < 3*RATIO; k++) begin
      send(IN_W'(100 + k), 1'b0, w);
      tot += w;
    end
    idle(3);
    chk("stream_no_stall", OUT_W'(tot), OUT_W'(0));
    chk("stream_words", OUT_W'(out_cyc.size()), OUT_W'(3));
    if (out_cyc.size() == 3) begin
      chk("stream_gap1", OUT_W'(out_cyc[1] - out_cyc[0]), OUT_W'(RATIO));
      chk("stream_gap2", OUT_W'(out_cyc[2] - out_cyc[1]), OUT_W'(RATIO));
    end

    // partial flush with sign bit set in last slice
    send(64'hA, 1'b0, w);
    send(64'h8000_0000_0000_0001, 1'b1, w);
    idle(3);

    // in_last on the final slot gives a normal full word
    for (int k = 0; k < RATIO; k++) send(IN_W'(200 + k), (k == RATIO-1), w);
    idle(3);

    // backpressure: 16 slices while out_ready=0
    out_ready = 1'b0;
    for (int k = 0; k < 2*RATIO; k++) send({$urandom(), $urandom()}, 1'b0, w);
    idle(3);
    @(negedge clk);
    chk("bp_in_ready_low", OUT_W'(in_ready), OUT_W'(1'b0));
    chk("bp_out_valid",    OUT_W'(out_valid), OUT_W'(1'b1));
    chk("bp_pending",      OUT_W'(exp_q.size()), OUT_W'(2));
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(5);
    chk("bp_drained", OUT_W'(exp_q.size()), OUT_W'(0));

    // reset mid-word
    for (int k = 0; k < 3; k++) send(IN_W'(k + 1), 1'b0, w);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", OUT_W'(out_valid), OUT_W'(1'b0));
    chk("mid_rst_in_ready",  OUT_W'(in_ready),  OUT_W'(1'b1));
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < RATIO; k++) send(IN_W'(16 + k), 1'b0, w);
    idle(3);
    chk("mid_rst_delivered", OUT_W'(exp_q.size()), OUT_W'(0));

    // randomized traffic
    rand_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send({$urandom(), $urandom()}, ($urandom_range(0, 5) == 0), w);
    end
    send({$urandom(), $urandom()}, 1'b1, w);
    rand_or = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("rand_drained", OUT_W'(exp_q.size()), OUT_W'(0));

    // small config: 1,2,3,F -> F321
    for (int k = 0; k < 4; k++) begin
      s_in_valid = 1'b1;
      s_in_data  = sv[k];
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("small_valid", OUT_W'(seen), OUT_W'(1'b1));
    chk("small_data",  OUT_W'(s_out_data),  OUT_W'(16'hF321));
    chk("small_count", OUT_W'(s_out_count), OUT_W'(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
